parity_frame_receiver: RTL and testbench

PARITY_FRAME_RECEIVER -- requirements
Module: parity_frame_receiver

---
 rtl/parity_frame_receiver.sv | 126 ++++++++++++
 tb/tb_parity_frame_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_receiver.sv
// Serial receiver for start + 4 data bits (LSB first) + parity + stop frames.
// Define PARITY_ERR_COUNT_EN to enable the saturating error-frame counter on err_count.
module parity_frame_receiver #(
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    input  logic       rx_valid,
    output logic [3:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic PAR_SENSE = (PARITY_ODD != 0);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic [3:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (rx_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_bit) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {rx_bit, shift_q[3:1]};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = rx_bit;
                    state_d = STOP;
                end
                STOP: begin
                    // Frame result is registered on the stop-bit sampling edge.
                    state_d      = IDLE;
                    data_out_d   = shift_q;
                    data_valid_d = 1'b1;
                    parity_err_d = (par_q != ((^shift_q) ^ PAR_SENSE));
                    frame_err_d  = !rx_bit;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if ((parity_err_d || frame_err_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_frame_receiver.sv
// Scoreboard bench for parity_frame_receiver: stimulus pushes expected frames, a monitor pops on data_valid.
module tb_parity_frame_receiver;

    localparam int unsigned PODD = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_bit = 1'b1;
    logic       rx_valid = 1'b0;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] err_count;

    parity_frame_receiver #(.PARITY_ODD(PODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_bit     (rx_bit),
        .rx_valid   (rx_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] last_data = '0;
    int         exp_cnt = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle against the scoreboard and simple output model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (data_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("data_out", 32'(data_out), 32'(e.data));
                        chk("parity_err", 32'(parity_err), 32'(e.perr));
                        chk("frame_err", 32'(frame_err), 32'(e.ferr));
                        last_data = e.data;
`ifdef PARITY_ERR_COUNT_EN
                        if ((e.perr || e.ferr) && exp_cnt < 255) exp_cnt++;
`endif
                    end
                end else begin
                    chk("idle_perr", 32'(parity_err), 32'd0);
                    chk("idle_ferr", 32'(frame_err), 32'd0);
                    chk("hold_data", 32'(data_out), 32'(last_data));
                end
                chk("err_count", 32'(err_count), 32'(exp_cnt));
            end
        end
    end

    task automatic send_bit(input logic b, input int unsigned gap);
        rx_bit   = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_bit   = 1'b1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [3:0] data, input bit bad_par, input logic stop,
                              input int unsigned gap, input bit rand_gap);
        exp_t e;
        logic par;
        logic [6:0] bits;
        par = (($countones(data) % 2) == 1) ^ (PODD != 0);
        if (bad_par) par = ~par;
        e.data = data;
        e.perr = bad_par;
        e.ferr = ~stop;
        sb.push_back(e);
        bits = {stop, par, data[3], data[2], data[1], data[0], 1'b0};
        for (int i = 0; i < 7; i++) begin
            send_bit(bits[i], rand_gap ? $urandom_range(0, 3) : gap);
        end
    endtask

    // Reset held alongside a start-bit strobe so rst must win.
    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_bit   = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        rx_valid  = 1'b0;
        rx_bit    = 1'b1;
        sb.delete();
        last_data = '0;
        exp_cnt   = 0;
        mon_en    = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;

        // Good frame, bad parity, bad stop.
        send_frame(4'hB, 1'b0, 1'b1, 0, 1'b0);
        send_frame(4'hB, 1'b1, 1'b1, 0, 1'b0);
        drain();
`ifdef PARITY_ERR_COUNT_EN
        chk("cnt_after_badpar", 32'(err_count), 32'd1);
`else
        chk("cnt_after_badpar", 32'(err_count), 32'd0);
`endif
        send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0);
        drain();
        chk("badstop_data", 32'(data_out), 32'h5);

        // Strobe gaps of three idle cycles after each bit.
        send_frame(4'hB, 1'b0, 1'b1, 3, 1'b0);
        drain();
        chk("gap_data", 32'(data_out), 32'hB);

        // Reset mid-frame: start + 2 data bits then abort.
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        do_reset();
        send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0);
        drain();
        chk("mid_rst_data", 32'(data_out), 32'h5);

        // Randomized frames with idle-line bits and random gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) send_bit(1'b1, 0);
            send_frame(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 3) != 0), 0, 1'b1);
        end
        drain();

        // Saturation of the error counter.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_frame(4'($urandom_range(0, 15)), 1'b1, 1'b1, 0, 1'b0);
        end
        drain();
`ifdef PARITY_ERR_COUNT_EN
        chk("sat_count", 32'(err_count), 32'd255);
`else
        chk("sat_count", 32'(err_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
